// File: rtl/id_ex_control_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_control_pkg
// Shared encodings for the ID/EX control stage: ALU command codes (shared
// with the ALU), instruction mode codes, data-proc opcodes, condition codes,
// status flag positions and the EX control bundle type.
// ---------------------------------------------------------------------------
package id_ex_control_pkg;

  // ALU command codes
  localparam logic [3:0] EX_NOP = 4'b0000;
  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_SBC = 4'b0101;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;
  localparam logic [3:0] EX_CMP = 4'b1100;
  localparam logic [3:0] EX_TST = 4'b1110;
  localparam logic [3:0] EX_LDR = 4'b1010;
  localparam logic [3:0] EX_STR = 4'b1011;

  // Instruction mode
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  // Data-proc opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Status flag positions within {Z,C,N,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic       s;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
    logic [3:0] command;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{valid: 1'b0, s: 1'b0, wb_en: 1'b0,
                                     mem_read: 1'b0, mem_write: 1'b0,
                                     branch: 1'b0, illegal: 1'b0,
                                     command: EX_NOP};

endpackage

// File: rtl/id_ex_control_cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
// Evaluates an ARM condition field against a {Z,C,N,V} flag vector.
//   i_cond  [3:0]  condition field
//   i_flags [3:0]  flags {Z,C,N,V}
//   o_pass         1 when the instruction should execute
// ---------------------------------------------------------------------------
module cond_check
  import id_ex_control_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_z, w_c, w_n, w_v;

  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_n = i_flags[FLAG_N];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// ---------------------------------------------------------------------------
// id_ex_control
// ID/EX pipeline control register: decodes the ID-stage instruction into EX
// controls, gates it on the condition field, and keeps the {Z,C,N,V} status
// register.
//   clk, rst                 clock, async active-high reset
//   in_valid                 ID presents an instruction
//   cond, mode, opcode, s_bit instruction fields
//   stall, flush             hold / kill the capture (flush wins)
//   sr_update                ALU flags for the instruction now in EX
//   ex_*                     registered EX controls
//   status, carry            status register and its C bit
// ---------------------------------------------------------------------------
module id_ex_control
  import id_ex_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] cond,
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] sr_update,
  output logic       ex_valid,
  output logic       ex_s,
  output logic       ex_wb_en,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic       ex_branch,
  output logic       ex_illegal,
  output logic [3:0] ex_command,
  output logic [3:0] status,
  output logic       carry
);

  ex_ctrl_t   r_ex;
  logic [3:0] r_status;

  ex_ctrl_t   w_dec;
  ex_ctrl_t   w_next;
  logic       w_legal;
  logic       w_pass;
  logic       w_sr_live;
  logic [3:0] w_eff_flags;

  // Flags produced by the instruction in EX are bypassed to the condition
  // check so a dependent instruction in ID sees them without a bubble.
  assign w_sr_live   = r_ex.valid && r_ex.s;
  assign w_eff_flags = w_sr_live ? sr_update : r_status;

  cond_check u_cond_check (
    .i_cond  (cond),
    .i_flags (w_eff_flags),
    .o_pass  (w_pass)
  );

  always_comb begin
    w_dec       = EX_BUBBLE;
    w_dec.valid = 1'b1;
    w_legal     = 1'b1;
    case (mode)
      MODE_DP: begin
        w_dec.wb_en = 1'b1;
        w_dec.s     = s_bit;
        case (opcode)
          OP_AND: w_dec.command = EX_AND;
          OP_EOR: w_dec.command = EX_EOR;
          OP_SUB: w_dec.command = EX_SUB;
          OP_ADD: w_dec.command = EX_ADD;
          OP_ADC: w_dec.command = EX_ADC;
          OP_SBC: w_dec.command = EX_SBC;
          OP_ORR: w_dec.command = EX_ORR;
          OP_MOV: w_dec.command = EX_MOV;
          OP_MVN: w_dec.command = EX_MVN;
          OP_TST: begin
            w_dec.command = EX_TST;
            w_dec.wb_en   = 1'b0;
            w_dec.s       = 1'b1;
          end
          OP_CMP: begin
            w_dec.command = EX_CMP;
            w_dec.wb_en   = 1'b0;
            w_dec.s       = 1'b1;
          end
          default: w_legal = 1'b0;
        endcase
      end
      MODE_MEM: begin
        if (s_bit) begin
          w_dec.command  = EX_LDR;
          w_dec.mem_read = 1'b1;
          w_dec.wb_en    = 1'b1;
        end else begin
          w_dec.command   = EX_STR;
          w_dec.mem_write = 1'b1;
        end
      end
      MODE_BR: w_dec.branch = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // An illegal instruction that would otherwise execute becomes a bubble
  // that only raises ex_illegal; killed or skipped ones leave no trace.
  always_comb begin
    w_next = EX_BUBBLE;
    if (in_valid && !flush && w_pass) begin
      if (w_legal) begin
        w_next = w_dec;
      end else begin
        w_next.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= EX_BUBBLE;
    end else if (flush || !stall) begin
      r_ex <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= 4'b0000;
    end else if (w_sr_live) begin
      r_status <= sr_update;
    end
  end

  assign ex_valid     = r_ex.valid;
  assign ex_s         = r_ex.s;
  assign ex_wb_en     = r_ex.wb_en;
  assign ex_mem_read  = r_ex.mem_read;
  assign ex_mem_write = r_ex.mem_write;
  assign ex_branch    = r_ex.branch;
  assign ex_illegal   = r_ex.illegal;
  assign ex_command   = r_ex.command;
  assign status       = r_status;
  assign carry        = r_status[FLAG_C];

endmodule

// File: tb/tb_id_ex_control.sv
module tb_id_ex_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       stall;
  logic       flush;
  logic [3:0] sr_update;
  logic       ex_valid, ex_s, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [3:0] ex_command;
  logic [3:0] status;
  logic       carry;

  id_ex_control dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .cond         (cond),
    .mode         (mode),
    .opcode       (opcode),
    .s_bit        (s_bit),
    .stall        (stall),
    .flush        (flush),
    .sr_update    (sr_update),
    .ex_valid     (ex_valid),
    .ex_s         (ex_s),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_branch    (ex_branch),
    .ex_illegal   (ex_illegal),
    .ex_command   (ex_command),
    .status       (status),
    .carry        (carry)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: EX bundle {valid,s,wb,mr,mw,br,ill,cmd[3:0]} and status.
  logic [10:0] m_ex;
  logic [3:0]  m_st;

  // ALU command per data-proc opcode, nibble n = opcode n; 0 marks illegal.
  localparam logic [63:0] DP_CMD = 64'h90170C0E05320486;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic z, cf, n, v;
    logic [7:0] base;
    z = f[3]; cf = f[2]; n = f[1]; v = f[0];
    // Odd condition codes are the negation of the even one below them.
    base = {1'b1, (!z && (n == v)), (n == v), (cf && !z), v, n, cf, z};
    return base[c[3:1]] ^ c[0];
  endfunction

  function automatic logic [10:0] model_ex(input logic v, input logic fl,
                                           input logic [3:0] c, input logic [1:0] md,
                                           input logic [3:0] op, input logic s,
                                           input logic [3:0] f);
    logic [3:0] cmd;
    logic       cmp;
    if (!v || fl || !cond_ok(c, f)) return 11'd0;
    case (md)
      2'd0: begin
        cmd = DP_CMD[op*4 +: 4];
        if (cmd == 4'd0) return 11'b00000010000;
        cmp = (cmd == 4'hC) || (cmd == 4'hE);
        return {1'b1, (cmp ? 1'b1 : s), !cmp, 4'b0000, cmd};
      end
      2'd1: return s ? {7'b1011000, 4'hA} : {7'b1000100, 4'hB};
      2'd2: return {7'b1000010, 4'h0};
      default: return 11'b00000010000;
    endcase
  endfunction

  function automatic logic [10:0] dut_bus();
    return {ex_valid, ex_s, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch,
            ex_illegal, ex_command};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("ex_bus", {21'd0, dut_bus()}, {21'd0, m_ex});
    check("status", {28'd0, status}, {28'd0, m_st});
    check("carry",  {31'd0, carry},  {31'd0, m_st[2]});
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] md,
                       input logic [3:0] op, input logic s, input logic st,
                       input logic fl, input logic [3:0] sr);
    in_valid = v; cond = c; mode = md; opcode = op; s_bit = s;
    stall = st; flush = fl; sr_update = sr;
  endtask

  // One clock: predict from the pre-edge inputs, then compare after the edge.
  task automatic step();
    logic        live;
    logic [3:0]  eff;
    logic [10:0] nex;
    logic [3:0]  nst;
    live = m_ex[10] && m_ex[9];
    eff  = live ? sr_update : m_st;
    nst  = live ? sr_update : m_st;
    nex  = (flush || !stall) ? model_ex(in_valid, flush, cond, mode, opcode, s_bit, eff) : m_ex;
    @(posedge clk);
    #1;
    m_ex = nex;
    m_st = nst;
    compare_model();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    m_ex = 11'd0;
    m_st = 4'd0;
    compare_model();
    rst = 1'b0;
  endtask

  initial begin
    m_ex = 11'd0;
    m_st = 4'd0;
    rst  = 1'b1;
    drive(0, 4'hE, 2'd0, 4'h0, 0, 0, 0, 4'h0);
    #2;
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_command", {28'd0, ex_command}, 32'd0);
    check("reset_status", {28'd0, status}, 32'd0);
    #5 rst = 1'b0;

    // ADDS, then flags arrive for it in EX
    drive(1, 4'hE, 2'd0, 4'b0100, 1, 0, 0, 4'h0);
    step();
    check("adds_command", {28'd0, ex_command}, 32'h2);
    check("adds_s", {31'd0, ex_s}, 32'd1);
    check("adds_wb", {31'd0, ex_wb_en}, 32'd1);
    drive(0, 4'hE, 2'd0, 4'h0, 0, 0, 0, 4'b1000);
    step();
    check("adds_status", {28'd0, status}, 32'h8);

    // Mid-stream reset
    mid_reset();
    check("midrst_status", {28'd0, status}, 32'd0);
    check("midrst_valid", {31'd0, ex_valid}, 32'd0);

    // CMP in EX, BEQ in ID using bypassed Z
    drive(1, 4'hE, 2'd0, 4'b1010, 0, 0, 0, 4'h0);
    step();
    check("cmp_command", {28'd0, ex_command}, 32'hC);
    check("cmp_s", {31'd0, ex_s}, 32'd1);
    drive(1, 4'h0, 2'd2, 4'h0, 0, 0, 0, 4'b1000);
    step();
    check("beq_bypass_branch", {31'd0, ex_branch}, 32'd1);
    check("beq_status", {28'd0, status}, 32'h8);

    // LDR, stall twice, then flush during stall
    drive(1, 4'hE, 2'd1, 4'h0, 1, 0, 0, 4'h0);
    step();
    check("ldr_command", {28'd0, ex_command}, 32'hA);
    check("ldr_mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive(1, 4'hE, 2'd0, 4'b1101, 0, 1, 0, 4'h0);
    step();
    step();
    check("stall_hold_cmd", {28'd0, ex_command}, 32'hA);
    check("stall_hold_mr", {31'd0, ex_mem_read}, 32'd1);
    drive(1, 4'hE, 2'd0, 4'b1101, 0, 1, 1, 4'h0);
    step();
    check("flush_bubble", {21'd0, dut_bus()}, 32'd0);

    // Illegal mode, then illegal opcode; each flagged for one cycle
    drive(1, 4'hE, 2'd3, 4'h0, 0, 0, 0, 4'h0);
    step();
    check("ill_mode_flag", {31'd0, ex_illegal}, 32'd1);
    check("ill_mode_valid", {31'd0, ex_valid}, 32'd0);
    drive(0, 4'hE, 2'd0, 4'h0, 0, 0, 0, 4'h0);
    step();
    check("ill_mode_clear", {31'd0, ex_illegal}, 32'd0);
    drive(1, 4'hE, 2'd0, 4'b0011, 1, 0, 0, 4'h0);
    step();
    check("ill_op_flag", {31'd0, ex_illegal}, 32'd1);
    drive(0, 4'hE, 2'd0, 4'h0, 0, 0, 0, 4'h0);
    step();
    check("ill_op_clear", {31'd0, ex_illegal}, 32'd0);

    // Never condition
    drive(1, 4'hF, 2'd0, 4'b1101, 0, 0, 0, 4'h0);
    step();
    check("never_bubble", {21'd0, dut_bus()}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      drive($urandom_range(0, 3) != 0,
            4'($urandom),
            2'($urandom),
            4'($urandom),
            1'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            4'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
